pipelined_adder: RTL

//   N-bit ripple-carry adder built from adder1 full-adder cells, cut into STAGES

---
 rtl/adder_pkg.sv | 15 +
 rtl/adder1.sv | 13 +
 rtl/adder_chunk.sv | 30 +++
 rtl/pipelined_adder.sv | 103 ++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared helpers for the pipelined ripple-carry adder: chunk width and per-stage control record.
package adder_pkg;

  function automatic int stage_width(input int n, input int stages);
    return (stages > 0) ? n / stages : n;
  endfunction

  // Control part of every stage register; the data slices are sized by the top's N.
  typedef struct packed {
    logic valid;
    logic carry;
    logic msb_cin;
  } stage_ctl_t;

endpackage

// File: rtl/adder1.sv
// Single-bit full adder cell, the building block of every carry chunk.
module adder1 (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/adder_chunk.sv
// Combinational W-bit ripple of adder1 cells; also exposes the carry into its top bit.
module adder_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out,
  output logic         c_msb
);

  logic [W:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < W; i++) begin : g_bit
    adder1 u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .c_in (carry[i]),
      .sum  (sum[i]),
      .c_out(carry[i+1])
    );
  end

  assign c_out = carry[W];
  assign c_msb = carry[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// N-bit ripple-carry adder split into STAGES carry chunks, one register stage per chunk,
// with a valid/ready handshake and carry-out / signed-overflow reporting.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int W = stage_width(N, STAGES);

  if ((STAGES < 1) || (STAGES > N) || ((N % STAGES) != 0)) begin : g_bad_params
    $error("pipelined_adder: STAGES must divide N and satisfy 1 <= STAGES <= N");
  end

  typedef struct packed {
    stage_ctl_t   ctl;
    logic [N-1:0] sum_lo;
    logic [N-1:0] a_hi;
    logic [N-1:0] b_hi;
  } stage_t;

  stage_t st  [STAGES];
  stage_t nxt [STAGES];
  logic   advance;

  // Handshake: input transfers on a rising edge with i_valid & o_ready, output transfers
  // with o_valid & i_ready; all stages shift together whenever the last stage can drain.
  assign advance = !o_valid || i_ready;
  assign o_ready = advance;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] sum_in;
    logic [N-1:0] sum_new;
    logic         cin;
    logic         vin;
    logic [W-1:0] chunk_sum;
    logic         chunk_cout;
    logic         chunk_cmsb;

    if (k == 0) begin : g_first
      assign op_a   = a;
      assign op_b   = b;
      assign sum_in = '0;
      assign cin    = c_in;
      assign vin    = i_valid;
    end else begin : g_next
      assign op_a   = st[k-1].a_hi;
      assign op_b   = st[k-1].b_hi;
      assign sum_in = st[k-1].sum_lo;
      assign cin    = st[k-1].ctl.carry;
      assign vin    = st[k-1].ctl.valid;
    end

    adder_chunk #(.W(W)) u_chunk (
      .a    (op_a[k*W +: W]),
      .b    (op_b[k*W +: W]),
      .c_in (cin),
      .sum  (chunk_sum),
      .c_out(chunk_cout),
      .c_msb(chunk_cmsb)
    );

    always_comb begin
      sum_new             = sum_in;
      sum_new[k*W +: W]   = chunk_sum;
    end

    assign nxt[k] = '{ctl:    '{valid: vin, carry: chunk_cout, msb_cin: chunk_cmsb},
                      sum_lo: sum_new,
                      a_hi:   op_a,
                      b_hi:   op_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < STAGES; k++) st[k] <= '0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) st[k] <= nxt[k];
    end
  end

  assign o_valid  = st[STAGES-1].ctl.valid;
  assign sum      = st[STAGES-1].sum_lo;
  assign c_out    = st[STAGES-1].ctl.carry;
  assign overflow = st[STAGES-1].ctl.carry ^ st[STAGES-1].ctl.msb_cin;

endmodule
